// File: rtl/pipelined_cla_adder_if.sv
// rtl/pipelined_cla_adder_if.sv - operand/result handshake bundle for the pipelined CLA adder
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Producer of operands / consumer of results
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // The adder itself
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined carry-look-ahead adder/subtractor with valid/ready flow control
module pipelined_cla_adder #(
  parameter int WIDTH  = 16,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  pipelined_cla_adder_if.slave bus
);
  localparam int SEG  = WIDTH / STAGES;
  localparam int NGRP = SEG / GROUP;
  localparam int LAST = STAGES - 1;

  // One segment: GROUP-bit look-ahead blocks, carry rippling from block to block.
  // Every carry inside a block is a flat sum of products of g/p and the block carry-in.
  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           ci);
    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG:0]   c;
    logic           cj;
    logic           t;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int grp = 0; grp < NGRP; grp++) begin
      for (int j = 1; j <= GROUP; j++) begin
        cj = c[grp*GROUP];
        for (int m = 0; m < j; m++) cj = cj & p[grp*GROUP + m];
        for (int m = 0; m < j; m++) begin
          t = g[grp*GROUP + m];
          for (int n = m + 1; n < j; n++) t = t & p[grp*GROUP + n];
          cj = cj | t;
        end
        c[grp*GROUP + j] = cj;
      end
    end
    return {c[SEG], p ^ c[SEG-1:0]};
  endfunction

  logic [WIDTH-1:0]  beff;
  logic              cin_eff;
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] rdy;
  logic              ovf_q;

  // Subtraction is a + ~b + 1; the caller's cin only matters for addition
  assign beff    = bus.sub ? ~bus.b : bus.b;
  assign cin_eff = bus.sub | bus.cin;

  // Ready ripples back from the output so bubbles collapse and a full pipe passes ready through
  always_comb begin
    rdy       = '0;
    rdy[LAST] = !v_q[LAST] || bus.out_ready;
    for (int k = LAST - 1; k >= 0; k--) rdy[k] = !v_q[k] || rdy[k+1];
  end

  assign bus.in_ready = rst_n && rdy[0];

  // Stage valid bits advance whenever the stage is allowed to load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
    end else begin
      if (rdy[0]) v_q[0] <= bus.in_valid;
      for (int k = 1; k < STAGES; k++) begin
        if (rdy[k]) v_q[k] <= v_q[k-1];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : stg
    logic [SEG-1:0]         sa;
    logic [SEG-1:0]         sb;
    logic                   sci;
    logic                   vin;
    logic [SEG:0]           r;
    logic [(k+1)*SEG-1:0]   sum_d;
    logic [(k+1)*SEG-1:0]   sum_q;
    logic                   c_q;

    if (k == 0) begin : src
      assign sa    = bus.a[SEG-1:0];
      assign sb    = beff[SEG-1:0];
      assign sci   = cin_eff;
      assign vin   = bus.in_valid;
      assign sum_d = r[SEG-1:0];
    end else begin : src
      assign sa    = stg[k-1].hi.ha_q[SEG-1:0];
      assign sb    = stg[k-1].hi.hb_q[SEG-1:0];
      assign sci   = stg[k-1].c_q;
      assign vin   = v_q[k-1];
      assign sum_d = {r[SEG-1:0], stg[k-1].sum_q};
    end

    assign r = seg_add(sa, sb, sci);

    // Capture the partial sum and segment carry; data holds while the stage is stalled
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q <= '0;
        c_q   <= 1'b0;
      end else if (rdy[k] && vin) begin
        sum_q <= sum_d;
        c_q   <= r[SEG];
      end
    end

    if (k < LAST) begin : hi
      localparam int HW = WIDTH - (k+1)*SEG;
      logic [HW-1:0] ha_d;
      logic [HW-1:0] hb_d;
      logic [HW-1:0] ha_q;
      logic [HW-1:0] hb_q;

      if (k == 0) begin : nx
        assign ha_d = bus.a[WIDTH-1:SEG];
        assign hb_d = beff[WIDTH-1:SEG];
      end else begin : nx
        assign ha_d = stg[k-1].hi.ha_q[HW+SEG-1:SEG];
        assign hb_d = stg[k-1].hi.hb_q[HW+SEG-1:SEG];
      end

      // Carry the operand bits that later stages still have to add
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ha_q <= '0;
          hb_q <= '0;
        end else if (rdy[k] && vin) begin
          ha_q <= ha_d;
          hb_q <= hb_d;
        end
      end
    end
  end

  // Overflow is decided in the last stage, which sees the operand MSBs and the result MSB together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (rdy[LAST] && stg[LAST].vin) begin
      ovf_q <= (stg[LAST].sa[SEG-1] == stg[LAST].sb[SEG-1]) &&
               (stg[LAST].r[SEG-1] != stg[LAST].sa[SEG-1]);
    end
  end

  assign bus.out_valid = v_q[LAST];
  assign bus.sum       = stg[LAST].sum_q;
  assign bus.cout      = stg[LAST].c_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb/tb_pipelined_cla_adder.sv - randomized and directed bench for the pipelined CLA adder
module tb_pipelined_cla_adder;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_cla_adder_if #(.WIDTH(W)) bus ();

  pipelined_cla_adder #(.WIDTH(W), .GROUP(4), .STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [W+1:0] exp_q[$];
  logic [W+1:0] o_res;
  logic         o_valid;
  logic         o_in_ready;
  logic         popped;
  logic         accepted;
  int           qn;

  function automatic logic [15:0] rnd16();
    logic [31:0] r;
    r = $urandom;
    return r[15:0];
  endfunction

  function automatic logic rnd1();
    logic [31:0] r;
    r = $urandom;
    return r[0];
  endfunction

  // Reference: plain integer arithmetic, result packed as {ovf, cout, sum}
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic su);
    int u;
    int s;
    logic [W+1:0] res;
    if (su) begin
      u = int'(x) - int'(y);
      s = int'($signed(x)) - int'($signed(y));
      res[W] = (x >= y);
    end else begin
      u = int'(x) + int'(y) + int'(ci);
      s = int'($signed(x)) + int'($signed(y)) + int'(ci);
      res[W] = u[16];
    end
    res[W-1:0] = u[15:0];
    res[W+1]   = (s > 32767) || (s < -32768);
    return res;
  endfunction

  // One cycle: drive after the falling edge, sample 1 time unit later, record the model on acceptance
  task automatic step(input logic v, input logic [15:0] aa, input logic [15:0] bb,
                      input logic ci, input logic su, input logic ordy);
    @(negedge clk);
    bus.in_valid  = v;
    bus.a         = aa;
    bus.b         = bb;
    bus.cin       = ci;
    bus.sub       = su;
    bus.out_ready = ordy;
    #1;
    o_valid    = bus.out_valid;
    o_in_ready = bus.in_ready;
    o_res      = {bus.ovf, bus.cout, bus.sum};
    popped     = o_valid && ordy;
    accepted   = v && o_in_ready;
    qn         = exp_q.size();
    if (accepted) exp_q.push_back(model(aa, bb, ci, su));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.a         = rnd16();
      bus.b         = rnd16();
      bus.cin       = rnd1();
      bus.sub       = rnd1();
      bus.out_ready = rnd1();
    end
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    vectors++;
    if (bus.sum !== 16'h0000) begin miscompares++; $display("FAIL reset_sum: got %h expected 0000", bus.sum); end
    vectors++;
    if (bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      miscompares++; $display("FAIL reset_flags: got cout=%b ovf=%b expected 0 0", bus.cout, bus.ovf);
    end
    vectors++;
    if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  // Directed single ops with an explicit latency check
  task automatic run_directed(input string name, input logic [15:0] aa, input logic [15:0] bb,
                              input logic ci, input logic su, input logic [W+1:0] want);
    step(1'b1, aa, bb, ci, su, 1'b1);
    vectors++;
    if (!accepted) begin miscompares++; $display("FAIL %s_accept: got in_ready=%b expected 1", name, o_in_ready); end
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (o_valid !== 1'b0) begin miscompares++; $display("FAIL %s_early: got out_valid=%b expected 0", name, o_valid); end
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (o_valid !== 1'b1 || o_res !== want) begin
      miscompares++;
      $display("FAIL %s: got valid=%b {ovf,cout,sum}=%h expected valid=1 %h", name, o_valid, o_res, want);
    end
    if (popped && exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic test_carry();
    run_directed("carry_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
    run_directed("carry_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
  endtask

  task automatic test_subtract();
    run_directed("sub_neg",    16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    run_directed("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
  endtask

  task automatic test_back_to_back();
    int npop;
    int first;
    int last;
    logic [15:0] ii;
    npop = 0; first = -1; last = -1;
    for (int i = 0; i < 14; i++) begin
      ii = 16'(i);
      if (i < 8) step(1'b1, ii, 16'h0100 * ii, 1'b0, 1'b0, 1'b1);
      else       step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      if (i < 8) begin
        vectors++;
        if (!accepted) begin miscompares++; $display("FAIL stream_accept: op %0d got in_ready=%b expected 1", i, o_in_ready); end
      end
      if (popped) begin
        vectors++;
        if (o_res !== {2'b00, 16'h0101 * 16'(npop)} || qn == 0 || o_res !== exp_q[0]) begin
          miscompares++;
          $display("FAIL stream_sum: result %0d got %h expected %h", npop, o_res, {2'b00, 16'h0101 * 16'(npop)});
        end
        if (qn > 0) void'(exp_q.pop_front());
        if (first < 0) first = i;
        last = i;
        npop++;
      end
    end
    vectors++;
    if (npop != 8 || last - first != 7) begin
      miscompares++;
      $display("FAIL stream_consecutive: got %0d results over %0d cycles expected 8 over 8", npop, last - first + 1);
    end
  endtask

  task automatic test_backpressure();
    logic [W+1:0] held;
    held = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < 10) step(1'b1, rnd16(), rnd16(), rnd1(), rnd1(), (i >= 4));
      else        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      if (i == 2) held = o_res;
      if (i == 2 || i == 3) begin
        vectors++;
        if (o_in_ready !== 1'b0 || o_valid !== 1'b1 || o_res !== held || qn != 2 || o_res !== exp_q[0]) begin
          miscompares++;
          $display("FAIL stall_hold: cycle %0d got in_ready=%b valid=%b res=%h inflight=%0d expected 0 1 %h 2",
                   i, o_in_ready, o_valid, o_res, qn, exp_q[0]);
        end
      end
      if (i == 4) begin
        vectors++;
        if (o_in_ready !== 1'b1) begin miscompares++; $display("FAIL ready_passthru: got %b expected 1", o_in_ready); end
      end
      if (popped) begin
        vectors++;
        if (qn == 0 || o_res !== exp_q[0]) begin
          miscompares++; $display("FAIL stall_order: got %h expected %h", o_res, (qn > 0) ? exp_q[0] : '0);
        end
        if (qn > 0) void'(exp_q.pop_front());
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL stall_drain: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_midflight();
    int npop;
    npop = 0;
    step(1'b1, rnd16(), rnd16(), 1'b0, 1'b0, 1'b0);
    step(1'b1, rnd16(), rnd16(), 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    vectors++;
    if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL midflight_loaded: got %b expected 1", bus.out_valid); end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      miscompares++; $display("FAIL midflight_clear: got valid=%b in_ready=%b expected 0 0", bus.out_valid, bus.in_ready);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = 16'h1234;
    bus.b         = 16'h0F0F;
    bus.cin       = 1'b1;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL first_accept: got %b expected 1", bus.in_ready); end
    else exp_q.push_back(model(16'h1234, 16'h0F0F, 1'b1, 1'b0));
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      if (popped) begin
        vectors++;
        if (qn == 0 || o_res !== exp_q[0] || i != 1) begin
          miscompares++; $display("FAIL post_reset_result: cycle %0d got %h expected %h", i, o_res, {2'b00, 16'h2144});
        end
        if (qn > 0) void'(exp_q.pop_front());
        npop++;
      end
    end
    vectors++;
    if (npop != 1) begin miscompares++; $display("FAIL post_reset_count: got %0d results expected 1", npop); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (i < 380) step(($urandom % 4) != 0, rnd16(), rnd16(), rnd1(), rnd1(), ($urandom % 3) != 0);
      else         step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      if (popped) begin
        vectors++;
        if (qn == 0 || o_res !== exp_q[0]) begin
          miscompares++; $display("FAIL random_result: cycle %0d got %h expected %h", i, o_res, (qn > 0) ? exp_q[0] : '0);
        end
        if (qn > 0) void'(exp_q.pop_front());
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL random_drain: got %0d left expected 0", exp_q.size()); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_carry();
    test_subtract();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
Parametrised, pipelined carry-look-ahead adder/subtractor with valid/ready handshakes on input and output. The WIDTH-bit operation is split into STAGES segments. Each segment is built from GROUP-bit look-ahead groups, and the inter-segment carry is registered. It is the next-generation adder for the multiplier datapaths: it accepts one operation per cycle, supports backpressure, and adds a subtract mode with signed-overflow detection.

Parameters:
WIDTH, 16, operand/result width in bits
GROUP, 4, bits per carry-look-ahead group (ripple between groups within a segment)
STAGES, 2, pipeline register stages (= latency); WIDTH must be divisible by GROUP*STAGES

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands valid
in_ready  output  1  adder can accept operands this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry in (ignored when sub=1)
sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
cout  output  1  carry out of MSB (sub: 1 = no borrow)
ovf  output  1  two's-complement overflow

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all stage valid bits = 0; out_valid=0; sum=0; cout=0; ovf=0. in_ready is forced to 0 while rst_n=0.
- Segment size: SEG = WIDTH/STAGES bits. Stage k computes bits [k*SEG +: SEG] from the registered carry of stage k-1. Stage 0 uses effective carry-in = sub ? 1 : cin.
- Effective B: beff = sub ? ~b : b, applied at stage 0.
- Registered state per stage: valid bit, low sum bits computed so far, carry out of the segment, and the not-yet-summed upper bits of a and beff. Also carried: a MSB and beff MSB, for the overflow computation.
- Output registers: the last stage register drives sum, cout and ovf directly. No combinational path from a/b to the outputs.
- ovf = (a[MSB] == beff[MSB]) && (sum[MSB] != a[MSB]).
- Handshake: transfer occurs on a rising edge where valid && ready.
  - Output side holds sum/cout/ovf stable while out_valid=1 && out_ready=0.
- Ready chain (combinational):
  - rdy[STAGES-1] = !v[STAGES-1] || out_ready
  - rdy[k] = !v[k] || rdy[k+1]
  - in_ready = rdy[0]
  - Bubbles collapse. Stage k loads from stage k-1 when rdy[k]. Its valid becomes v[k-1] (stage 0: in_valid).
- Latency: an operation accepted at edge t is presented with out_valid=1 after edge t+STAGES-1, provided no stall. STAGES=1 gives a fully registered single-cycle adder.
- Throughput: one result per cycle while out_ready=1.
- Ordering: results leave strictly in acceptance order. No drop, no duplication.
- Full pipeline with out_ready=0: in_ready=0. When out_ready returns high, in_ready rises in the same cycle (pass-through of ready).
- Simultaneous output pop and input push on a full pipeline: both occur on the same edge.
- Reset mid-operation: all in-flight operations are discarded immediately (asynchronous). No result emerges after reset release. First acceptance is possible on the first edge with rst_n=1.
- Operands and mode are sampled only on transfer. Values on a/b/sub/cin while in_valid=0 have no effect.

Test Plan:
1. Reset: assert rst_n=0 with random inputs -> out_valid=0, sum=16'h0000, cout=0, ovf=0, in_ready=0. Release -> in_ready=1.
2. Carry across segment: a=16'hFFFF, b=16'h0001, cin=0, sub=0 accepted at edge t -> out_valid after edge t+1; sum=16'h0000, cout=1, ovf=0. Then a=16'h7FFF, b=16'h0001 -> sum=16'h8000, cout=0, ovf=1.
3. Subtract:
   - a=16'h0005, b=16'h0007, sub=1, cin=1 (ignored) -> sum=16'hFFFE, cout=0, ovf=0.
   - a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, cout=1, ovf=1.
4. Streaming: 8 back-to-back ops (a=i, b=16'h0100*i, sub=0, cin=0), out_ready=1 -> 8 consecutive out_valid cycles, sum=16'h0101*i in order.
5. Backpressure: stream continuously, hold out_ready=0 for 4 cycles -> pipeline holds exactly 2 ops, in_ready=0, outputs stable. On release, all results emerge in order, none lost or duplicated.
6. Reset mid-flight: 2 ops in flight, pulse rst_n low for half a cycle -> out_valid=0 immediately. Neither result appears after release.
